// File: rtl/uart_pkg.sv
// Shared UART definitions: parity codes, receiver state encoding and the
// baud-tick divider calculation used by the oversampling RX (and future TX).
package uart_pkg;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_START = 3'd1;
  localparam logic [2:0] ST_DATA  = 3'd2;
  localparam logic [2:0] ST_PAR   = 3'd3;
  localparam logic [2:0] ST_STOP  = 3'd4;
  localparam logic [2:0] ST_BRK   = 3'd5;

  function automatic int calc_tick_div(input int clk_freq, input int baud, input int os);
    return clk_freq / (baud * os);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running divider producing a one-cycle tick every DIV clocks; shared
// by the oversampling receiver and transmitter.
module uart_baud_tick #(
  parameter int DIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else if (cnt_reg == CNT_LAST) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  assign tick = (cnt_reg == CNT_LAST);

endmodule

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver with majority vote, parity/framing/overrun flags
// and a valid/ready output. Define UART_RX_BREAK_DET_EN to enable break detection.
module uart_rx_os
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD_RATE  = 115200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 rx_perr,
  output logic                 rx_ferr,
  output logic                 rx_overrun,
  output logic                 rx_break
);

  localparam int TICK_DIV = calc_tick_div(CLK_FREQ, BAUD_RATE, OVERSAMPLE);
  localparam int OSW      = $clog2(OVERSAMPLE);
  localparam int BCW      = $clog2(DATA_BITS);

  localparam logic [OSW-1:0] OS_VOTE = OSW'(OVERSAMPLE / 2 + 1);
  localparam logic [OSW-1:0] OS_LAST = OSW'(OVERSAMPLE - 1);
  localparam logic [BCW-1:0] BIT_LAST  = BCW'(DATA_BITS - 1);
  localparam logic [BCW-1:0] STOP_LAST = BCW'(STOP_BITS - 1);

  if (TICK_DIV < 1) begin : g_bad_tick_div
    $error("uart_rx_os: CLK_FREQ too low for BAUD_RATE*OVERSAMPLE");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9 || STOP_BITS < 1 || STOP_BITS > 2 ||
      OVERSAMPLE < 8 || (OVERSAMPLE % 2) != 0 || PARITY < 0 || PARITY > 2) begin : g_bad_cfg
    $error("uart_rx_os: unsupported frame configuration");
  end

  logic tick;

  uart_baud_tick #(.DIV(TICK_DIV)) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick)
  );

  logic                 rx_meta_reg, rx_sync_reg;
  logic [1:0]           samp_reg;
  logic [2:0]           state_reg, state_next;
  logic [OSW-1:0]       os_cnt_reg, os_cnt_next;
  logic [BCW-1:0]       bit_cnt_reg, bit_cnt_next;
  logic [DATA_BITS-1:0] shift_reg, shift_next;
  logic                 perr_reg, perr_next;
  logic                 ferr_reg, ferr_next;
  logic                 done_reg, done_next;
  logic                 vote, vote_tick, last_tick;
`ifdef UART_RX_BREAK_DET_EN
  logic                 zero_reg, zero_next;
  logic                 brk_reg, brk_next;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_reg <= 1'b1;
      rx_sync_reg <= 1'b1;
      samp_reg    <= 2'b11;
    end else begin
      rx_meta_reg <= rx;
      rx_sync_reg <= rx_meta_reg;
      if (tick) samp_reg <= {samp_reg[0], rx_sync_reg};
    end
  end

  // On the vote tick samp_reg holds the two earlier mid-bit samples.
  assign vote      = (samp_reg[1] & samp_reg[0]) | (samp_reg[1] & rx_sync_reg) |
                     (samp_reg[0] & rx_sync_reg);
  assign vote_tick = tick && (os_cnt_reg == OS_VOTE);
  assign last_tick = tick && (os_cnt_reg == OS_LAST);

  always_comb begin
    state_next   = state_reg;
    os_cnt_next  = os_cnt_reg;
    bit_cnt_next = bit_cnt_reg;
    shift_next   = shift_reg;
    perr_next    = perr_reg;
    ferr_next    = ferr_reg;
    done_next    = 1'b0;
`ifdef UART_RX_BREAK_DET_EN
    zero_next    = zero_reg;
    brk_next     = 1'b0;
`endif
    if (tick) os_cnt_next = (os_cnt_reg == OS_LAST) ? '0 : os_cnt_reg + 1'b1;

    case (state_reg)
      ST_IDLE: begin
        os_cnt_next = '0;
        if (!rx_sync_reg) begin
          state_next   = ST_START;
          bit_cnt_next = '0;
          perr_next    = 1'b0;
          ferr_next    = 1'b0;
`ifdef UART_RX_BREAK_DET_EN
          zero_next    = 1'b1;
`endif
        end
      end
      ST_START: begin
        if (vote_tick && vote) state_next = ST_IDLE;
        else if (last_tick)    state_next = ST_DATA;
      end
      ST_DATA: begin
        if (vote_tick) begin
          shift_next = {vote, shift_reg[DATA_BITS-1:1]};
`ifdef UART_RX_BREAK_DET_EN
          zero_next  = zero_reg & ~vote;
`endif
        end
        if (last_tick) begin
          if (bit_cnt_reg == BIT_LAST) begin
            bit_cnt_next = '0;
            state_next   = (PARITY != PARITY_NONE) ? ST_PAR : ST_STOP;
          end else begin
            bit_cnt_next = bit_cnt_reg + 1'b1;
          end
        end
      end
      ST_PAR: begin
        if (vote_tick) begin
          perr_next = (^{shift_reg, vote}) ^ (PARITY == PARITY_ODD);
`ifdef UART_RX_BREAK_DET_EN
          zero_next = zero_reg & ~vote;
`endif
        end
        if (last_tick) state_next = ST_STOP;
      end
      ST_STOP: begin
        if (vote_tick) begin
          ferr_next = ferr_reg | ~vote;
          if (bit_cnt_reg == STOP_LAST) begin
            state_next = ST_IDLE;
            done_next  = 1'b1;
          end
`ifdef UART_RX_BREAK_DET_EN
          // Line held low through the first stop bit: swallow the frame.
          if (bit_cnt_reg == '0 && zero_reg && !vote) begin
            state_next = ST_BRK;
            done_next  = 1'b0;
            brk_next   = 1'b1;
          end
`endif
        end
        if (last_tick) bit_cnt_next = bit_cnt_reg + 1'b1;
      end
`ifdef UART_RX_BREAK_DET_EN
      ST_BRK: begin
        if (rx_sync_reg) state_next = ST_IDLE;
      end
`endif
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= ST_IDLE;
      os_cnt_reg  <= '0;
      bit_cnt_reg <= '0;
      shift_reg   <= '0;
      perr_reg    <= 1'b0;
      ferr_reg    <= 1'b0;
      done_reg    <= 1'b0;
`ifdef UART_RX_BREAK_DET_EN
      zero_reg    <= 1'b0;
      brk_reg     <= 1'b0;
`endif
    end else begin
      state_reg   <= state_next;
      os_cnt_reg  <= os_cnt_next;
      bit_cnt_reg <= bit_cnt_next;
      shift_reg   <= shift_next;
      perr_reg    <= perr_next;
      ferr_reg    <= ferr_next;
      done_reg    <= done_next;
`ifdef UART_RX_BREAK_DET_EN
      zero_reg    <= zero_next;
      brk_reg     <= brk_next;
`endif
    end
  end

  logic [DATA_BITS-1:0] rx_data_reg;
  logic                 rx_valid_reg, rx_perr_reg, rx_ferr_reg, rx_overrun_reg;
  logic                 handshake;

  assign handshake = rx_valid_reg && rx_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_data_reg    <= '0;
      rx_valid_reg   <= 1'b0;
      rx_perr_reg    <= 1'b0;
      rx_ferr_reg    <= 1'b0;
      rx_overrun_reg <= 1'b0;
    end else begin
      if (handshake) begin
        rx_valid_reg   <= 1'b0;
        rx_overrun_reg <= 1'b0;
      end
      if (done_reg) begin
        if (!rx_valid_reg || rx_ready) begin
          rx_data_reg  <= shift_reg;
          rx_perr_reg  <= perr_reg;
          rx_ferr_reg  <= ferr_reg;
          rx_valid_reg <= 1'b1;
        end else begin
          rx_overrun_reg <= 1'b1;
        end
      end
    end
  end

  assign rx_data    = rx_data_reg;
  assign rx_valid   = rx_valid_reg;
  assign rx_perr    = rx_perr_reg;
  assign rx_ferr    = rx_ferr_reg;
  assign rx_overrun = rx_overrun_reg;
`ifdef UART_RX_BREAK_DET_EN
  assign rx_break   = brk_reg;
`else
  assign rx_break   = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_os.sv
// Randomised bench for uart_rx_os: three instances (8N1, 7E1, 8N2) checked
// against a frame-level reference model; break test under UART_RX_BREAK_DET_EN.
module tb_uart_rx_os;
  import uart_pkg::*;

  localparam int BIT_CLKS = 32;  // TICK_DIV 2 * OVERSAMPLE 16

  typedef struct packed {
    logic [8:0] data;
    logic       perr;
    logic       ferr;
  } word_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] rx_line;
  logic [2:0] rdy;

  logic [7:0] data_a, data_c;
  logic [6:0] data_b;
  logic valid_a, perr_a, ferr_a, ovr_a, brk_a;
  logic valid_b, perr_b, ferr_b, ovr_b, brk_b;
  logic valid_c, perr_c, ferr_c, ovr_c, brk_c;

  int cfg_bits [3] = '{8, 7, 8};
  int cfg_par  [3] = '{0, 2, 0};
  int cfg_stop [3] = '{1, 1, 2};

  int n_checks = 0;
  int n_errors = 0;
  int brk_cnt  = 0;
  word_t got_a[$], got_b[$], got_c[$];

  always #5 clk = ~clk;

  uart_rx_os #(.CLK_FREQ(3686400), .BAUD_RATE(115200), .DATA_BITS(8), .PARITY(0),
               .STOP_BITS(1), .OVERSAMPLE(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .rx(rx_line[0]), .rx_data(data_a), .rx_valid(valid_a),
    .rx_ready(rdy[0]), .rx_perr(perr_a), .rx_ferr(ferr_a), .rx_overrun(ovr_a), .rx_break(brk_a));

  uart_rx_os #(.CLK_FREQ(3686400), .BAUD_RATE(115200), .DATA_BITS(7), .PARITY(2),
               .STOP_BITS(1), .OVERSAMPLE(16)) dut_b (
    .clk(clk), .rst_n(rst_n), .rx(rx_line[1]), .rx_data(data_b), .rx_valid(valid_b),
    .rx_ready(rdy[1]), .rx_perr(perr_b), .rx_ferr(ferr_b), .rx_overrun(ovr_b), .rx_break(brk_b));

  uart_rx_os #(.CLK_FREQ(3686400), .BAUD_RATE(115200), .DATA_BITS(8), .PARITY(0),
               .STOP_BITS(2), .OVERSAMPLE(16)) dut_c (
    .clk(clk), .rst_n(rst_n), .rx(rx_line[2]), .rx_data(data_c), .rx_valid(valid_c),
    .rx_ready(rdy[2]), .rx_perr(perr_c), .rx_ferr(ferr_c), .rx_overrun(ovr_c), .rx_break(brk_c));

  function automatic word_t mk_word(input logic [8:0] d, input logic p, input logic f);
    word_t w;
    w.data = d;
    w.perr = p;
    w.ferr = f;
    return w;
  endfunction

  // Accepted words are recorded between edges, when valid and ready are stable.
  always @(negedge clk) begin
    if (valid_a && rdy[0]) got_a.push_back(mk_word(9'(data_a), perr_a, ferr_a));
    if (valid_b && rdy[1]) got_b.push_back(mk_word(9'(data_b), perr_b, ferr_b));
    if (valid_c && rdy[2]) got_c.push_back(mk_word(9'(data_c), perr_c, ferr_c));
    if (brk_a) brk_cnt++;
  end

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: expected word from the bits put on the line.
  function automatic word_t model_frame(input int idx, input logic [8:0] data,
                                        input logic pbit, input logic [1:0] stops);
    word_t w;
    logic [8:0] mask;
    int ones;
    mask   = (9'h1 << cfg_bits[idx]) - 9'h1;
    w.data = data & mask;
    ones   = $countones(w.data) + int'(pbit);
    case (cfg_par[idx])
      1:       w.perr = (ones % 2) == 0;
      2:       w.perr = (ones % 2) == 1;
      default: w.perr = 1'b0;
    endcase
    w.ferr = !stops[0] || (cfg_stop[idx] == 2 && !stops[1]);
    return w;
  endfunction

  task automatic idle_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input int idx, input logic b);
    rx_line[idx] = b;
    idle_clks(BIT_CLKS);
  endtask

  task automatic send_frame(input int idx, input logic [8:0] data, input logic pbit,
                            input logic [1:0] stops);
    drive_bit(idx, 1'b0);
    for (int i = 0; i < cfg_bits[idx]; i++) drive_bit(idx, data[i]);
    if (cfg_par[idx] != 0) drive_bit(idx, pbit);
    for (int s = 0; s < cfg_stop[idx]; s++) drive_bit(idx, stops[s]);
    rx_line[idx] = 1'b1;
    idle_clks(BIT_CLKS);
  endtask

  task automatic take_word(input int idx, output word_t w, output int n);
    w = '0;
    n = 0;
    case (idx)
      0: begin n = got_a.size(); if (n > 0) w = got_a.pop_front(); end
      1: begin n = got_b.size(); if (n > 0) w = got_b.pop_front(); end
      default: begin n = got_c.size(); if (n > 0) w = got_c.pop_front(); end
    endcase
  endtask

  task automatic run_frame(input int idx, input logic [8:0] data, input logic pbit,
                           input logic [1:0] stops, input string tag);
    word_t exp_w, got_w;
    int n;
    send_frame(idx, data, pbit, stops);
    exp_w = model_frame(idx, data, pbit, stops);
    take_word(idx, got_w, n);
    $display("frame %s: sent 0x%0h par %0b stop %0b -> got 0x%0h perr %0b ferr %0b (%0d words)",
             tag, data, pbit, stops, got_w.data, got_w.perr, got_w.ferr, n);
    check_value({tag, "_count"}, n, 1);
    check_value({tag, "_data"}, got_w.data, exp_w.data);
    check_value({tag, "_perr"}, got_w.perr, exp_w.perr);
    check_value({tag, "_ferr"}, got_w.ferr, exp_w.ferr);
  endtask

  task automatic check_a_zero(input string tag);
    check_value({tag, "_valid"}, valid_a, 0);
    check_value({tag, "_data"}, data_a, 0);
    check_value({tag, "_perr"}, perr_a, 0);
    check_value({tag, "_ferr"}, ferr_a, 0);
    check_value({tag, "_ovr"}, ovr_a, 0);
    check_value({tag, "_brk"}, brk_a, 0);
  endtask

  initial begin
    word_t w;
    int n, b0;
    logic [8:0] d;
    rst_n   = 1'b0;
    rx_line = 3'b111;
    rdy     = 3'b000;
    idle_clks(5);
    check_a_zero("reset");
    rst_n = 1'b1;
    idle_clks(5);
    rdy = 3'b111;

    run_frame(0, 9'h0A5, 1'b0, 2'b11, "8n1_a5");
    check_value("8n1_a5_ovr", ovr_a, 0);
    for (int i = 0; i < 6; i++) begin
      d = 9'($urandom_range(1, 255));
      run_frame(0, d, 1'b0, ($urandom_range(0, 3) == 0) ? 2'b10 : 2'b11, "8n1_rand");
    end

    run_frame(1, 9'h041, 1'b1, 2'b11, "7e1_badpar");
    run_frame(1, 9'h041, 1'b0, 2'b11, "7e1_goodpar");
    for (int i = 0; i < 5; i++) begin
      d = 9'($urandom_range(1, 127));
      run_frame(1, d, 1'($urandom_range(0, 1)), 2'b11, "7e1_rand");
    end

    run_frame(2, 9'h03C, 1'b0, 2'b01, "8n2_stop2low");
    check_value("8n2_idle", dut_c.state_reg, ST_IDLE);
    for (int i = 0; i < 5; i++) begin
      d = 9'($urandom_range(1, 255));
      run_frame(2, d, 1'b0, 2'($urandom_range(0, 3)), "8n2_rand");
    end

    // Three-tick low glitch on an idle line.
    rx_line[0] = 1'b0;
    idle_clks(6);
    rx_line[0] = 1'b1;
    idle_clks(2 * BIT_CLKS);
    $display("glitch: %0d words, state %0d", got_a.size(), dut_a.state_reg);
    check_value("glitch_words", got_a.size(), 0);
    check_value("glitch_idle", dut_a.state_reg, ST_IDLE);

    // Overrun: second word arrives while the first is still held.
    rdy[0] = 1'b0;
    send_frame(0, 9'h011, 1'b0, 2'b11);
    send_frame(0, 9'h022, 1'b0, 2'b11);
    $display("overrun: valid %0b data 0x%0h ovr %0b", valid_a, data_a, ovr_a);
    check_value("ovr_valid", valid_a, 1);
    check_value("ovr_data", data_a, 8'h11);
    check_value("ovr_flag", ovr_a, 1);
    check_value("ovr_no_hs", got_a.size(), 0);
    rdy[0] = 1'b1;
    idle_clks(1);
    rdy[0] = 1'b0;
    take_word(0, w, n);
    $display("overrun handshake: got 0x%0h, valid %0b ovr %0b", w.data, valid_a, ovr_a);
    check_value("ovr_hs_count", n, 1);
    check_value("ovr_hs_data", w.data, 9'h011);
    check_value("ovr_hs_valid", valid_a, 0);
    check_value("ovr_hs_clear", ovr_a, 0);

    // Reset in the middle of a frame, with a word already held.
    send_frame(0, 9'h077, 1'b0, 2'b11);
    check_value("pre_rst_valid", valid_a, 1);
    drive_bit(0, 1'b0);
    for (int i = 0; i < 3; i++) drive_bit(0, 1'b1);
    rst_n = 1'b0;
    #2;
    check_a_zero("midrst");
    idle_clks(4);
    rst_n = 1'b1;
    idle_clks(BIT_CLKS);
    rdy[0] = 1'b1;
    run_frame(0, 9'h05A, 1'b0, 2'b11, "after_rst_5a");

`ifdef UART_RX_BREAK_DET_EN
    b0 = brk_cnt;
    rx_line[0] = 1'b0;
    idle_clks(12 * BIT_CLKS);
    rx_line[0] = 1'b1;
    idle_clks(2 * BIT_CLKS);
    $display("break: %0d pulses, %0d words", brk_cnt - b0, got_a.size());
    check_value("brk_pulses", brk_cnt - b0, 1);
    check_value("brk_words", got_a.size(), 0);
    check_value("brk_idle", dut_a.state_reg, ST_IDLE);
    run_frame(0, 9'h001, 1'b0, 2'b11, "after_brk_01");
`else
    b0 = 0;
    check_value("brk_tied", brk_cnt, b0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
